// File: rtl/rv_sdram_bridge.sv
// rv_sdram_bridge: adapts the 32-bit valid/ready CPU memory bus to the 16-bit toggle
// request/ack port of the SDRAM arbiter. Each access is split into low/high halfword
// transactions. Write halves with no strobes are skipped. A watchdog aborts stalled halves.
module rv_sdram_bridge #(
   parameter int unsigned TIMEOUT_CYCLES = 1024,
   parameter int unsigned TO_W           = 11
) (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic        i_mem_valid,
   input  logic [22:0] i_mem_addr,
   input  logic [31:0] i_mem_wdata,
   input  logic [3:0]  i_mem_wstrb,
   output logic        o_mem_ready,
   output logic [31:0] o_mem_rdata,
   output logic        o_mem_err,
   output logic [22:0] o_rv_addr,
   output logic        o_rv_word,
   output logic [31:0] o_rv_wdata,
   output logic [3:0]  o_rv_wstrb,
   output logic [1:0]  o_rv_ds,
   output logic        o_rv_req,
   input  logic        i_rv_req_ack,
   input  logic [15:0] i_rv_dout,
   output logic        o_busy
);

   typedef enum logic [2:0] {StIdle, StLoWait, StHiWait, StDone, StDrain} state_e;

   state_e            state_q, state_d;
   logic              req_q, req_d;
   logic              word_q, word_d;
   logic [22:0]       addr_q, addr_d;
   logic [31:0]       wdata_q, wdata_d;
   logic [3:0]        wstrb_q, wstrb_d;       // full strobes of the accepted access
   logic [3:0]        rv_wstrb_q, rv_wstrb_d; // strobes masked to the active half
   logic [1:0]        ds_q, ds_d;
   logic [31:0]       rdata_q, rdata_d;
   logic              ready_q, ready_d;
   logic              err_q, err_d;
   logic [TO_W-1:0]   wd_q, wd_d;

   logic ack_match;
   logic wd_expire;
   logic is_read;
   logic unused_addr;

   assign ack_match   = (i_rv_req_ack == req_q);
   assign wd_expire   = (TIMEOUT_CYCLES != 0) && (wd_q == TO_W'(TIMEOUT_CYCLES - 1));
   assign is_read     = (wstrb_q == 4'b0000);
   assign unused_addr = ^i_mem_addr[1:0];

   // Next-state, request issue, read-data assembly and watchdog.
   always_comb begin
      state_d    = state_q;
      req_d      = req_q;
      word_d     = word_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      wstrb_d    = wstrb_q;
      rv_wstrb_d = rv_wstrb_q;
      ds_d       = ds_q;
      rdata_d    = rdata_q;
      ready_d    = 1'b0;
      err_d      = 1'b0;
      wd_d       = wd_q;
      case (state_q)
         StIdle: begin
            // ready_q high here means the CPU has not yet seen completion; ignore valid.
            if (i_mem_valid && !ready_q) begin
               addr_d  = {i_mem_addr[22:2], 2'b00};
               wdata_d = i_mem_wdata;
               wstrb_d = i_mem_wstrb;
               rdata_d = '0;
               req_d   = ~req_q;
               wd_d    = '0;
               if (i_mem_wstrb == 4'b0000 || i_mem_wstrb[1:0] != 2'b00) begin
                  word_d     = 1'b0;
                  ds_d       = (i_mem_wstrb == 4'b0000) ? 2'b11 : i_mem_wstrb[1:0];
                  rv_wstrb_d = {2'b00, i_mem_wstrb[1:0]};
                  state_d    = StLoWait;
               end else begin
                  word_d     = 1'b1;
                  ds_d       = i_mem_wstrb[3:2];
                  rv_wstrb_d = {i_mem_wstrb[3:2], 2'b00};
                  state_d    = StHiWait;
               end
            end
         end
         StLoWait: begin
            if (ack_match) begin
               rdata_d[15:0] = i_rv_dout;
               if (is_read || wstrb_q[3:2] != 2'b00) begin
                  word_d     = 1'b1;
                  ds_d       = is_read ? 2'b11 : wstrb_q[3:2];
                  rv_wstrb_d = {wstrb_q[3:2], 2'b00};
                  req_d      = ~req_q;
                  wd_d       = '0;
                  state_d    = StHiWait;
               end else begin
                  state_d = StDone;
               end
            end else if (wd_expire) begin
               ready_d = 1'b1;
               err_d   = 1'b1;
               rdata_d = '1;
               state_d = StDrain;
            end else begin
               wd_d = wd_q + 1'b1;
            end
         end
         StHiWait: begin
            if (ack_match) begin
               rdata_d[31:16] = i_rv_dout;
               state_d        = StDone;
            end else if (wd_expire) begin
               ready_d = 1'b1;
               err_d   = 1'b1;
               rdata_d = '1;
               state_d = StDrain;
            end else begin
               wd_d = wd_q + 1'b1;
            end
         end
         StDone: begin
            ready_d = 1'b1;
            state_d = StIdle;
         end
         StDrain: begin
            // Wait out the abandoned toggle so only one is ever outstanding; its data is dropped.
            if (ack_match) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state_q    <= StIdle;
         req_q      <= 1'b0;
         word_q     <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         wstrb_q    <= '0;
         rv_wstrb_q <= '0;
         ds_q       <= '0;
         rdata_q    <= '0;
         ready_q    <= 1'b0;
         err_q      <= 1'b0;
         wd_q       <= '0;
      end else begin
         state_q    <= state_d;
         req_q      <= req_d;
         word_q     <= word_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         wstrb_q    <= wstrb_d;
         rv_wstrb_q <= rv_wstrb_d;
         ds_q       <= ds_d;
         rdata_q    <= rdata_d;
         ready_q    <= ready_d;
         err_q      <= err_d;
         wd_q       <= wd_d;
      end
   end

   assign o_mem_ready = ready_q;
   assign o_mem_rdata = rdata_q;
   assign o_mem_err   = err_q;
   assign o_rv_addr   = addr_q;
   assign o_rv_word   = word_q;
   assign o_rv_wdata  = wdata_q;
   assign o_rv_wstrb  = rv_wstrb_q;
   assign o_rv_ds     = ds_q;
   assign o_rv_req    = req_q;
   assign o_busy      = (state_q != StIdle);

endmodule
